// File: rtl/mult_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// mult_share_arbiter_if
//   Request/grant and result channels between the requesting blocks and the
//   shared-multiplier arbiter.
//
//   req       requester side -> arbiter   per-requester request level
//   a_bus     requester side -> arbiter   operand A, requester i on [4i+3:4i]
//   b_bus     requester side -> arbiter   operand B, same packing
//   gnt       arbiter -> requester side   one-hot grant, one cycle per grant
//   done_vld  arbiter -> consumer         result valid
//   done_rdy  consumer -> arbiter         consumer accepts result
//   done_id   arbiter -> consumer         index of requester owning done_p
//   done_p    arbiter -> consumer         captured 8-bit product
//
//   master : the requesters/consumer view, slave : the arbiter view.
// ---------------------------------------------------------------------------
interface mult_share_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] a_bus;
    logic [4*NREQ-1:0] b_bus;
    logic [NREQ-1:0]   gnt;
    logic              done_vld;
    logic              done_rdy;
    logic [2:0]        done_id;
    logic [7:0]        done_p;

    modport master (
        output req, a_bus, b_bus, done_rdy,
        input  gnt, done_vld, done_id, done_p
    );

    modport slave (
        input  req, a_bus, b_bus, done_rdy,
        output gnt, done_vld, done_id, done_p
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// ---------------------------------------------------------------------------
// mult_share_arbiter
//   Shares one combinational 4x4 unsigned multiplier among NREQ requesters.
//   A round-robin arbiter picks a winner in IDLE, registers its operands onto
//   the multiplier inputs, waits SETTLE cycles, captures the product and
//   returns it with the winner's index over a valid/ready channel.
//
//   Parameters: NREQ (2..8) requesters, SETTLE (1..15) hold cycles before
//   the product is captured. The bus interface must carry the same NREQ.
//
//   clk       clock, all state changes on the rising edge
//   rst_n     synchronous reset, active low
//   bus       slave side of mult_share_arbiter_if (req/a_bus/b_bus/gnt,
//             done_vld/done_rdy/done_id/done_p)
//   busy      high whenever the FSM is not IDLE
//   mul_a     registered operand A to the multiplier
//   mul_b     registered operand B to the multiplier
//   mul_p     product returned by the multiplier
// ---------------------------------------------------------------------------
module mult_share_arbiter #(
    parameter int NREQ   = 4,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mult_share_arbiter_if.slave   bus,
    output logic                  busy,
    output logic [3:0]            mul_a,
    output logic [3:0]            mul_b,
    input  logic [7:0]            mul_p
);
    localparam int IW = 3;   // index width, enough for 8 requesters
    localparam int CW = 4;   // settle counter width, enough for 15

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [NREQ-1:0] gnt_reg, gnt_next;
    logic [3:0]      mul_a_reg, mul_a_next;
    logic [3:0]      mul_b_reg, mul_b_next;
    logic            done_vld_reg, done_vld_next;
    logic [2:0]      done_id_reg, done_id_next;
    logic [7:0]      done_p_reg, done_p_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [IW-1:0]   ptr_reg, ptr_next;

    logic [3:0]      a_lane   [NREQ];
    logic [3:0]      b_lane   [NREQ];
    logic [4:0]      rank_raw [NREQ];
    logic [4:0]      rank     [NREQ];

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [4:0]      win_rank;
    logic [3:0]      sel_a, sel_b;

    // Per-requester operand lanes and round-robin rank. Rank 0 belongs to
    // the requester just after the last winner (ptr+1), rank NREQ-1 to the
    // last winner itself, so the lowest requesting rank wins.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
            assign a_lane[gi]   = bus.a_bus[4*gi +: 4];
            assign b_lane[gi]   = bus.b_bus[4*gi +: 4];
            assign rank_raw[gi] = 5'(gi) + 5'(NREQ - 1) - 5'(ptr_reg);
            assign rank[gi]     = (rank_raw[gi] >= 5'(NREQ)) ?
                                  (rank_raw[gi] - 5'(NREQ)) : rank_raw[gi];
        end
    endgenerate

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_rank  = '1;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req[i] && (rank[i] < win_rank)) begin
                win_found = 1'b1;
                win_rank  = rank[i];
                win_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx == IW'(i)) begin
                sel_a = a_lane[i];
                sel_b = b_lane[i];
            end
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (win_found)          state_next = CALC;
            CALC: if (cnt_reg == '0)      state_next = RESP;
            RESP: if (bus.done_rdy)       state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs and datapath next values ----------------
    always_comb begin
        gnt_next      = '0;
        mul_a_next    = mul_a_reg;
        mul_b_next    = mul_b_reg;
        done_vld_next = done_vld_reg;
        done_id_next  = done_id_reg;
        done_p_next   = done_p_reg;
        cnt_next      = cnt_reg;
        ptr_next      = ptr_reg;
        busy          = (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    for (int i = 0; i < NREQ; i++) begin
                        gnt_next[i] = (win_idx == IW'(i));
                    end
                    mul_a_next   = sel_a;
                    mul_b_next   = sel_b;
                    ptr_next     = win_idx;
                    done_id_next = win_idx;
                    cnt_next     = CW'(SETTLE - 1);
                end
            end
            CALC: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    done_p_next   = mul_p;
                    done_vld_next = 1'b1;
                end
            end
            RESP: begin
                // Result stays frozen until the consumer takes it.
                if (bus.done_rdy) begin
                    done_vld_next = 1'b0;
                end
            end
            default: begin
                done_vld_next = 1'b0;
            end
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_reg      <= '0;
            mul_a_reg    <= '0;
            mul_b_reg    <= '0;
            done_vld_reg <= 1'b0;
            done_id_reg  <= '0;
            done_p_reg   <= '0;
            cnt_reg      <= '0;
            ptr_reg      <= IW'(NREQ - 1);   // requester 0 gets first priority
        end else begin
            gnt_reg      <= gnt_next;
            mul_a_reg    <= mul_a_next;
            mul_b_reg    <= mul_b_next;
            done_vld_reg <= done_vld_next;
            done_id_reg  <= done_id_next;
            done_p_reg   <= done_p_next;
            cnt_reg      <= cnt_next;
            ptr_reg      <= ptr_next;
        end
    end

    assign bus.gnt      = gnt_reg;
    assign bus.done_vld = done_vld_reg;
    assign bus.done_id  = done_id_reg;
    assign bus.done_p   = done_p_reg;
    assign mul_a        = mul_a_reg;
    assign mul_b        = mul_b_reg;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mult_share_arbiter
//   Two arbiters (SETTLE=1 and SETTLE=3, four requesters each) driven with
//   randomized operands. A round-robin pick over the requester list plus
//   plain a*b arithmetic give the expected grant, index, product and timing.
// ---------------------------------------------------------------------------
module tb_mult_share_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // index 0: SETTLE=1 instance, index 1: SETTLE=3 instance
    logic        rst_v  [2];
    logic [3:0]  req_v  [2];
    logic [15:0] a_v    [2];
    logic [15:0] b_v    [2];
    logic        rdy_v  [2];
    logic [3:0]  gnt_w  [2];
    logic        busy_w [2];
    logic [3:0]  mula_w [2];
    logic [3:0]  mulb_w [2];
    logic [7:0]  mulp_w [2];
    logic        vld_w  [2];
    logic [2:0]  id_w   [2];
    logic [7:0]  p_w    [2];
    int          last_w [2];
    int          settle_of [2] = '{1, 3};

    mult_share_arbiter_if #(.NREQ(4)) if1 ();
    mult_share_arbiter_if #(.NREQ(4)) if3 ();

    assign if1.req      = req_v[0];
    assign if1.a_bus    = a_v[0];
    assign if1.b_bus    = b_v[0];
    assign if1.done_rdy = rdy_v[0];
    assign gnt_w[0]     = if1.gnt;
    assign vld_w[0]     = if1.done_vld;
    assign id_w[0]      = if1.done_id;
    assign p_w[0]       = if1.done_p;

    assign if3.req      = req_v[1];
    assign if3.a_bus    = a_v[1];
    assign if3.b_bus    = b_v[1];
    assign if3.done_rdy = rdy_v[1];
    assign gnt_w[1]     = if3.gnt;
    assign vld_w[1]     = if3.done_vld;
    assign id_w[1]      = if3.done_id;
    assign p_w[1]       = if3.done_p;

    // the shared multipliers
    assign mulp_w[0] = 8'(mula_w[0]) * 8'(mulb_w[0]);
    assign mulp_w[1] = 8'(mula_w[1]) * 8'(mulb_w[1]);

    mult_share_arbiter #(.NREQ(4), .SETTLE(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_v[0]),
        .bus   (if1),
        .busy  (busy_w[0]),
        .mul_a (mula_w[0]),
        .mul_b (mulb_w[0]),
        .mul_p (mulp_w[0])
    );

    mult_share_arbiter #(.NREQ(4), .SETTLE(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_v[1]),
        .bus   (if3),
        .busy  (busy_w[1]),
        .mul_a (mula_w[1]),
        .mul_b (mulb_w[1]),
        .mul_p (mulp_w[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round-robin reference: first requester after the last winner.
    function automatic int pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic do_reset(input int d);
        rst_v[d] = 1'b0;
        req_v[d] = 4'b0000;
        rdy_v[d] = 1'b0;
        tick();
        tick();
        rst_v[d] = 1'b1;
        last_w[d] = 3;
    endtask

    // One full grant / compute / respond sequence. Leaves the FSM in IDLE
    // with the non-winning requests still raised.
    task automatic apply(input int d, input logic [3:0] r, input logic [15:0] a,
                         input logic [15:0] b, input int stall, input bit rdy_early);
        int w;
        int exp_p;
        logic [15:0] av, bv;
        logic [3:0] oh, ea, eb;
        av = a;
        bv = b;
        w = pick(r, last_w[d]);
        ea = av[4*w +: 4];
        eb = bv[4*w +: 4];
        exp_p = int'(ea) * int'(eb);
        oh = 4'b0001 << w;
        req_v[d] = r;
        a_v[d]   = a;
        b_v[d]   = b;
        rdy_v[d] = 1'b0;
        tick();
        vectors++; if (gnt_w[d] !== oh) begin miscompares++; $display("FAIL grant d%0d: got %b want %b", d, gnt_w[d], oh); end
        vectors++; if (busy_w[d] !== 1'b1) begin miscompares++; $display("FAIL busy_calc d%0d: got %b want 1", d, busy_w[d]); end
        vectors++; if (mula_w[d] !== ea || mulb_w[d] !== eb) begin miscompares++; $display("FAIL operands d%0d: got %0d,%0d want %0d,%0d", d, mula_w[d], mulb_w[d], ea, eb); end
        vectors++; if (vld_w[d] !== 1'b0) begin miscompares++; $display("FAIL early_vld d%0d: got %b want 0", d, vld_w[d]); end
        req_v[d] = r & ~oh;
        rdy_v[d] = rdy_early;
        for (int c = 1; c < settle_of[d]; c++) begin
            tick();
            vectors++; if (vld_w[d] !== 1'b0 || gnt_w[d] !== 4'b0000) begin miscompares++; $display("FAIL settle d%0d: vld %b gnt %b want 0 0000", d, vld_w[d], gnt_w[d]); end
        end
        tick();
        vectors++; if (vld_w[d] !== 1'b1) begin miscompares++; $display("FAIL vld_rise d%0d: got %b want 1", d, vld_w[d]); end
        vectors++; if (id_w[d] !== 3'(w)) begin miscompares++; $display("FAIL done_id d%0d: got %0d want %0d", d, id_w[d], w); end
        vectors++; if (int'(p_w[d]) != exp_p) begin miscompares++; $display("FAIL done_p d%0d: got %0d want %0d", d, p_w[d], exp_p); end
        vectors++; if (gnt_w[d] !== 4'b0000) begin miscompares++; $display("FAIL gnt_resp d%0d: got %b want 0000", d, gnt_w[d]); end
        rdy_v[d] = 1'b0;
        for (int s = 0; s < stall; s++) begin
            tick();
            vectors++; if (vld_w[d] !== 1'b1 || int'(p_w[d]) != exp_p || id_w[d] !== 3'(w)) begin miscompares++; $display("FAIL stall_hold d%0d: vld %b p %0d id %0d want 1 %0d %0d", d, vld_w[d], p_w[d], id_w[d], exp_p, w); end
            vectors++; if (gnt_w[d] !== 4'b0000 || busy_w[d] !== 1'b1) begin miscompares++; $display("FAIL stall_ctl d%0d: gnt %b busy %b want 0000 1", d, gnt_w[d], busy_w[d]); end
        end
        rdy_v[d] = 1'b1;
        tick();
        vectors++; if (vld_w[d] !== 1'b0 || busy_w[d] !== 1'b0 || gnt_w[d] !== 4'b0000) begin miscompares++; $display("FAIL to_idle d%0d: vld %b busy %b gnt %b want 0 0 0000", d, vld_w[d], busy_w[d], gnt_w[d]); end
        vectors++; if (mula_w[d] !== ea || mulb_w[d] !== eb) begin miscompares++; $display("FAIL mul_hold d%0d: got %0d,%0d want %0d,%0d", d, mula_w[d], mulb_w[d], ea, eb); end
        rdy_v[d] = 1'b0;
        last_w[d] = w;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b0;
            req_v[d] = 4'b1111;
            a_v[d]   = 16'hFFFF;
            b_v[d]   = 16'hFFFF;
            rdy_v[d] = 1'b0;
        end
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            vectors++; if (gnt_w[d] !== 4'b0000 || busy_w[d] !== 1'b0) begin miscompares++; $display("FAIL reset_ctl d%0d: gnt %b busy %b want 0000 0", d, gnt_w[d], busy_w[d]); end
            vectors++; if (vld_w[d] !== 1'b0 || p_w[d] !== 8'd0 || id_w[d] !== 3'd0) begin miscompares++; $display("FAIL reset_resp d%0d: vld %b p %0d id %0d want 0 0 0", d, vld_w[d], p_w[d], id_w[d]); end
            vectors++; if (mula_w[d] !== 4'd0 || mulb_w[d] !== 4'd0) begin miscompares++; $display("FAIL reset_mul d%0d: got %0d,%0d want 0,0", d, mula_w[d], mulb_w[d]); end
            req_v[d] = 4'b0000;
            rst_v[d] = 1'b1;
            last_w[d] = 3;
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            vectors++; if (busy_w[d] !== 1'b0 || gnt_w[d] !== 4'b0000) begin miscompares++; $display("FAIL idle_hold d%0d: busy %b gnt %b want 0 0000", d, busy_w[d], gnt_w[d]); end
        end
    endtask

    task automatic test_single();
        logic [15:0] a, b;
        a = 16'($urandom);
        b = 16'($urandom);
        a[7:4] = 4'd15;
        b[7:4] = 4'd15;
        apply(0, 4'b0010, a, b, 0, 1'b0);
    endtask

    task automatic test_fairness();
        do_reset(0);
        for (int k = 0; k < 6; k++) begin
            apply(0, 4'b1111, 16'($urandom), 16'($urandom), 0, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        apply(0, 4'b1001, 16'($urandom), 16'($urandom), 5, 1'b0);
        // the loser is still requesting and must win on the first IDLE edge
        apply(0, req_v[0], 16'($urandom), 16'($urandom), 0, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++) begin
            apply(0, 4'($urandom_range(1, 15)), 16'($urandom), 16'($urandom),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_in_calc();
        int w;
        apply(1, 4'b0100, 16'($urandom), 16'($urandom), 0, 1'b0);
        w = pick(4'b1111, last_w[1]);
        req_v[1] = 4'b1111;
        a_v[1]   = 16'($urandom);
        b_v[1]   = 16'($urandom);
        tick();
        vectors++; if (gnt_w[1] !== (4'b0001 << w)) begin miscompares++; $display("FAIL calc_grant: got %b want %b", gnt_w[1], 4'b0001 << w); end
        // counter now holds SETTLE-1 = 2; abort the computation
        rst_v[1] = 1'b0;
        tick();
        tick();
        rst_v[1] = 1'b1;
        req_v[1] = 4'b0000;
        last_w[1] = 3;
        for (int c = 0; c < 6; c++) begin
            vectors++; if (vld_w[1] !== 1'b0 || busy_w[1] !== 1'b0) begin miscompares++; $display("FAIL abort c%0d: vld %b busy %b want 0 0", c, vld_w[1], busy_w[1]); end
            tick();
        end
        apply(1, 4'b1111, 16'($urandom), 16'($urandom), 0, 1'b0);
    endtask

    task automatic test_exhaustive();
        logic [15:0] a, b;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                a = 16'($urandom);
                b = 16'($urandom);
                a[11:8] = 4'(ai);
                b[11:8] = 4'(bi);
                apply(1, 4'b0100, a, b, 0, 1'b0);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_v[d]  = 1'b0;
            req_v[d]  = 4'b0000;
            a_v[d]    = 16'h0000;
            b_v[d]    = 16'h0000;
            rdy_v[d]  = 1'b0;
            last_w[d] = 3;
        end
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_random();
        test_reset_in_calc();
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
